// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bit positions and controller state encoding
// for the multicycle ALU and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] OP_PASS_B = 4'h0;
  localparam logic [3:0] OP_ADD    = 4'h1;
  localparam logic [3:0] OP_SUB    = 4'h2;
  localparam logic [3:0] OP_MUL    = 4'h3;
  localparam logic [3:0] OP_DIV    = 4'h4;
  localparam logic [3:0] OP_AND    = 4'h5;
  localparam logic [3:0] OP_OR     = 4'h6;
  localparam logic [3:0] OP_NOR    = 4'h7;
  localparam logic [3:0] OP_SRL    = 4'h8;
  localparam logic [3:0] OP_SLL    = 4'h9;
  localparam logic [3:0] OP_SRA    = 4'hA;
  localparam logic [3:0] OP_LUI    = 4'hB;
  localparam logic [3:0] OP_MFHI   = 4'hC;
  localparam logic [3:0] OP_MFLO   = 4'hD;
  localparam logic [3:0] OP_SLT    = 4'hE;
  localparam logic [3:0] OP_RSVD   = 4'hF;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative WIDTH-step shift-add multiplier / restoring divider on operand magnitudes.
// go latches operands; fin flags the last step; hi/lo present the sign-corrected result afterwards.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [3:0]       op,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             divz,
  output logic             fin
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] hi_q, lo_q, md_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, div_q, neg_a_q, neg_b_q, bz_q;

  logic             neg_a, neg_b;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, shifted;
  logic             ge;
  logic [WIDTH-1:0] hi_step, lo_step;
  logic [2*WIDTH-1:0] prod;

  assign neg_a = sign & a[WIDTH-1];
  assign neg_b = sign & b[WIDTH-1];
  assign a_mag = neg_a ? -a : a;
  assign b_mag = neg_b ? -b : b;

  // hi_q doubles as partial product (MUL) and partial remainder (DIV); lo_q
  // holds the multiplier / dividend bits being consumed and the quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, md_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    ge      = shifted >= {1'b0, md_q};
    if (div_q) begin
      hi_step = ge ? (shifted[WIDTH-1:0] - md_q) : shifted[WIDTH-1:0];
      lo_step = {lo_q[WIDTH-2:0], ge};
    end else begin
      hi_step = sum[WIDTH:1];
      lo_step = {sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q    <= '0;
      lo_q    <= '0;
      md_q    <= '0;
      cnt_q   <= '0;
      run_q   <= 1'b0;
      div_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      bz_q    <= 1'b0;
    end else if (go) begin
      hi_q    <= '0;
      lo_q    <= a_mag;
      md_q    <= b_mag;
      cnt_q   <= CNT_W'(WIDTH - 1);
      run_q   <= 1'b1;
      div_q   <= (op == OP_DIV);
      neg_a_q <= neg_a;
      neg_b_q <= neg_b;
      bz_q    <= (b == '0);
    end else if (run_q) begin
      hi_q  <= hi_step;
      lo_q  <= lo_step;
      cnt_q <= cnt_q - 1'b1;
      if (cnt_q == '0) run_q <= 1'b0;
    end
  end

  // Quotient sign follows the operand signs, remainder follows the dividend.
  always_comb begin
    prod = {hi_q, lo_q};
    if (neg_a_q ^ neg_b_q) prod = -prod;
    if (div_q) begin
      hi = neg_a_q ? -hi_q : hi_q;
      if (bz_q)                   lo = '1;
      else if (neg_a_q ^ neg_b_q) lo = -lo_q;
      else                        lo = lo_q;
    end else begin
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
    end
  end

  assign divz = div_q & bz_q;
  assign fin  = run_q && (cnt_q == '0);

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU: single-cycle ops register Y/flags on the accepting edge; MUL/DIV take WIDTH+1 cycles.
// start is only sampled in IDLE, so requests while busy are dropped with no side effects.
module multicycle_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       operation,
  input  logic             sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] outHI,
  output logic [WIDTH-1:0] outLO,
  output logic [3:0]       carryFlags,
  output logic             busy,
  output logic             done,
  output logic             divz
);
  import alu_pkg::*;

  localparam int M = WIDTH - 1;

  state_e           state_q;
  logic [WIDTH-1:0] y_q, hi_q, lo_q;
  logic [3:0]       flags_q;
  logic             done_q, divz_q;

  logic             go;
  logic [WIDTH-1:0] md_hi, md_lo;
  logic             md_divz, md_fin;

  logic [WIDTH:0]   add_s;
  logic [WIDTH-1:0] sub_d, sc_res;
  logic [SHAMT_W-1:0] shamt;
  logic             lt, sc_c, sc_v;
  logic [3:0]       sc_flags;

  assign go = (state_q == S_IDLE) && start && is_multicycle(operation);

  mul_div_unit #(.WIDTH(WIDTH)) u_mul_div (
    .clk   (clk),
    .reset (reset),
    .go    (go),
    .op    (operation),
    .sign  (sign),
    .a     (A),
    .b     (B),
    .hi    (md_hi),
    .lo    (md_lo),
    .divz  (md_divz),
    .fin   (md_fin)
  );

  always_comb begin
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    add_s  = {1'b0, A} + {1'b0, B};
    sub_d  = A - B;
    shamt  = B[SHAMT_W-1:0];
    lt     = sign ? ($signed(A) < $signed(B)) : (A < B);
    case (operation)
      OP_PASS_B: sc_res = B;
      OP_ADD: begin
        sc_res = add_s[WIDTH-1:0];
        sc_c   = add_s[WIDTH];
        sc_v   = sign & (A[M] == B[M]) & (add_s[M] != A[M]);
      end
      OP_SUB: begin
        sc_res = sub_d;
        sc_c   = (A >= B);
        sc_v   = sign & (A[M] != B[M]) & (sub_d[M] != A[M]);
      end
      OP_AND:  sc_res = A & B;
      OP_OR:   sc_res = A | B;
      OP_NOR:  sc_res = ~(A | B);
      OP_SRL:  sc_res = A >> shamt;
      OP_SLL:  sc_res = A << shamt;
      OP_SRA:  sc_res = $signed(A) >>> shamt;
      OP_LUI:  sc_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: sc_res = hi_q;
      OP_MFLO: sc_res = lo_q;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, lt};
      OP_MUL, OP_DIV, OP_RSVD: sc_res = '0;
    endcase
    sc_flags         = '0;
    sc_flags[FLAG_N] = sc_res[M];
    sc_flags[FLAG_Z] = (sc_res == '0);
    sc_flags[FLAG_C] = sc_c;
    sc_flags[FLAG_V] = sc_v;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      y_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (is_multicycle(operation)) begin
              state_q <= S_CALC;
            end else begin
              y_q     <= sc_res;
              flags_q <= sc_flags;
              divz_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        S_CALC: if (md_fin) state_q <= S_FIX;
        S_FIX: begin
          hi_q            <= md_hi;
          lo_q            <= md_lo;
          y_q             <= md_lo;
          flags_q         <= '0;
          flags_q[FLAG_N] <= md_lo[M];
          flags_q[FLAG_Z] <= (md_lo == '0);
          divz_q          <= md_divz;
          done_q          <= 1'b1;
          state_q         <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Y          = y_q;
  assign outHI      = hi_q;
  assign outLO      = lo_q;
  assign carryFlags = flags_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign divz       = divz_q;

endmodule
